// File: rtl/lfsr_prbs_checker.sv
// rtl/lfsr_prbs_checker.sv - self-synchronising PRBS checker for the x^6+x^5+1 LFSR stream
module lfsr_prbs_checker #(
  parameter int LOCK_CNT = 12,
  parameter int LOSS_CNT = 4,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_vld,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             bit_err,
  output logic [CNT_W-1:0] err_count
);

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int LW = $clog2(LOSS_CNT + 1);
  localparam logic [MW-1:0] LOCK_TGT = MW'(LOCK_CNT);
  localparam logic [LW-1:0] LOSS_TGT = LW'(LOSS_CNT);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [5:0]       sr_q, sr_d;
  logic [2:0]       fill_q, fill_d;
  logic [MW-1:0]    match_q, match_d;
  logic [LW-1:0]    miss_q, miss_d;
  logic             locked_q, locked_d;
  logic             bit_err_q, bit_err_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;

  logic             exp_bit;
  logic             count_err;
  logic [MW-1:0]    match_inc;
  logic [LW-1:0]    miss_inc;

  // Next-state: hunt for six seed bits, verify predictions, then flywheel while locked
  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    fill_d      = fill_q;
    match_d     = match_q;
    miss_d      = miss_q;
    bit_err_d   = 1'b0;
    err_count_d = err_count_q;
    count_err   = 1'b0;
    exp_bit     = sr_q[5] ^ sr_q[4];
    match_inc   = match_q + 1'b1;
    miss_inc    = miss_q + 1'b1;

    if (din_vld) begin
      case (state_q)
        HUNT: begin
          sr_d   = {sr_q[4:0], din};
          fill_d = fill_q + 3'd1;
          if (fill_q == 3'd5) begin
            state_d = VERIFY;
            match_d = '0;
          end
        end
        VERIFY: begin
          sr_d = {sr_q[4:0], din};
          // An all-zero register can never come from this LFSR, so treat it as a failed verify
          if ((din == exp_bit) && (sr_q != 6'd0)) begin
            match_d = match_inc;
            if (match_inc == LOCK_TGT) begin
              state_d = LOCKED;
              miss_d  = '0;
            end
          end else begin
            state_d = HUNT;
            fill_d  = 3'd0;
          end
        end
        LOCKED: begin
          // Feed back the prediction so a corrupted input bit never pollutes later predictions
          sr_d = {sr_q[4:0], exp_bit};
          if (din == exp_bit) begin
            miss_d = '0;
          end else begin
            bit_err_d = 1'b1;
            count_err = 1'b1;
            miss_d    = miss_inc;
            if (miss_inc == LOSS_TGT) begin
              state_d = HUNT;
              fill_d  = 3'd0;
            end
          end
        end
        default: begin
          state_d = HUNT;
          fill_d  = 3'd0;
        end
      endcase
    end

    if (clr_cnt) begin
      err_count_d = '0;
    end else if (count_err && (err_count_q != {CNT_W{1'b1}})) begin
      err_count_d = err_count_q + 1'b1;
    end

    locked_d = (state_d == LOCKED);
  end

  // State and output registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= HUNT;
      sr_q        <= 6'd0;
      fill_q      <= 3'd0;
      match_q     <= '0;
      miss_q      <= '0;
      locked_q    <= 1'b0;
      bit_err_q   <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      fill_q      <= fill_d;
      match_q     <= match_d;
      miss_q      <= miss_d;
      locked_q    <= locked_d;
      bit_err_q   <= bit_err_d;
      err_count_q <= err_count_d;
    end
  end

  assign locked    = locked_q;
  assign bit_err   = bit_err_q;
  assign err_count = err_count_q;

endmodule
